// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor. Computes a - b one bit
//               per clock, LSB first, with a single full-subtractor cell and a
//               borrow flip-flop. Handshake is start / busy / done. The result
//               and flags are held in output registers until the next
//               operation completes.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               start      request, sampled only in IDLE
//               a, b       minuend / subtrahend, sampled on the accepting edge
//               busy       high while the operation is shifting
//               done       one-cycle pulse, result registers valid
//               diff       a - b modulo 2^WIDTH
//               borrowout  final borrow (a < b unsigned)
//               overflow   signed overflow of a - b
//               zero       diff == 0
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout,
    output logic             overflow,
    output logic             zero
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_br;
    logic [CW-1:0]     r_cnt;

    logic              w_last;
    logic              w_d;
    logic              w_br_next;
    logic [WIDTH-1:0]  w_res_next;

    // Full-subtractor cell operating on the current LSBs of the operand
    // shift registers.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == C_LAST);

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:              w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            diff      <= '0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    if (w_last) begin
                        r_cnt     <= '0;
                        // On the last bit the operand LSBs are the original
                        // sign bits, so the signed-overflow test needs no
                        // separately latched copy of the MSBs.
                        diff      <= w_res_next;
                        borrowout <= w_br_next;
                        overflow  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
                        zero      <= ~|w_res_next;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor, with an
//               8-bit instance for the directed vectors and a 4-bit instance
//               for the full operand sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] diff;
    logic       borrowout, overflow, zero;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [3:0] diff4;
    logic       borrowout4, overflow4, zero4;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .borrowout(borrowout), .overflow(overflow), .zero(zero)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4),
        .borrowout(borrowout4), .overflow(overflow4), .zero(zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one 8-bit operation and follow it to its done pulse. Returns the
    // number of edges from the accepting edge to done (-1 on timeout), the
    // number of busy cycles, and whether the result registers stayed at their
    // pre-operation values until done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int bcnt, output bit held);
        logic [10:0] pre;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        pre   = {diff, borrowout, overflow, zero};
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        lat   = -1;
        bcnt  = 0;
        held  = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
            if ({diff, borrowout, overflow, zero} !== pre) held = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        start4 = 1'b0;
        a4     = 4'h0;
        b4     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, borrowout, overflow, zero} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b required all 0",
                     busy, done, diff, borrowout, overflow, zero);
        end
        checks++;
        if ({busy4, done4, diff4, borrowout4, overflow4, zero4} !== 8'h00) begin
            errors++;
            $display("FAIL reset4: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b required all 0",
                     busy4, done4, diff4, borrowout4, overflow4, zero4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        bit held;
        run8(8'h05, 8'h03, lat, bcnt, held);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 8", lat);
        end
        checks++;
        if (bcnt !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 8", bcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b required 0", busy);
        end
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got diff=%h bo=%b ov=%b z=%b required 02 0 0 0",
                     diff, borrowout, overflow, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got %b required 0", done);
        end
    endtask

    task automatic test_borrow();
        int lat, bcnt;
        bit held;
        run8(8'h03, 8'h05, lat, bcnt, held);
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'hFE, 1'b1, 1'b0, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL borrow: got diff=%h bo=%b ov=%b z=%b lat=%0d required FE 1 0 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
    endtask

    task automatic test_overflow();
        int lat, bcnt;
        bit held;
        run8(8'h80, 8'h01, lat, bcnt, held);
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h7F, 1'b0, 1'b1, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL overflow_neg: got diff=%h bo=%b ov=%b z=%b lat=%0d required 7F 0 1 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
        run8(8'h7F, 8'hFF, lat, bcnt, held);
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h80, 1'b1, 1'b1, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL overflow_pos: got diff=%h bo=%b ov=%b z=%b lat=%0d required 80 1 1 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
    endtask

    task automatic test_zero_hold();
        int lat, bcnt;
        bit held;
        run8(8'h2A, 8'h2A, lat, bcnt, held);
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h00, 1'b0, 1'b0, 1'b1} || lat !== 8) begin
            errors++;
            $display("FAIL zero_result: got diff=%h bo=%b ov=%b z=%b lat=%0d required 00 0 0 1 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
        run8(8'h01, 8'h00, lat, bcnt, held);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL zero_hold: got held=%b required 1", held);
        end
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h01, 1'b0, 1'b0, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL zero_next: got diff=%h bo=%b ov=%b z=%b lat=%0d required 01 0 0 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int k = 0; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            // Present a competing request on the edges E0+3 and E0+7.
            if (k == 2 || k == 6) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h0F, 1'b0, 1'b0, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL ignore_start: got diff=%h bo=%b ov=%b z=%b lat=%0d required 0F 0 0 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        int lat, bcnt, dseen;
        bit held;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrowout, overflow, zero} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b required all 0",
                     busy, done, diff, borrowout, overflow, zero);
        end
        rst_n = 1'b1;
        dseen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles required 0", dseen);
        end
        run8(8'h33, 8'h11, lat, bcnt, held);
        checks++;
        if ({diff, borrowout, overflow, zero} !== {8'h22, 1'b0, 1'b0, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL after_reset: got diff=%h bo=%b ov=%b z=%b lat=%0d required 22 0 0 0 lat 8",
                     diff, borrowout, overflow, zero, lat);
        end
    endtask

    task automatic test_back_to_back();
        int idx, cyc, prev;
        logic [3:0] ea, eb, ed;
        logic       ebo, eov, ez;
        idx  = 0;
        cyc  = 0;
        prev = -1;
        @(negedge clk);
        start4 = 1'b1;
        a4     = 4'h0;
        b4     = 4'h0;
        while (idx < 256 && cyc < 256 * 6 + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done4) begin
                ea  = idx[7:4];
                eb  = idx[3:0];
                ed  = ea - eb;
                ebo = (ea < eb);
                eov = (ea[3] != eb[3]) && (ed[3] != ea[3]);
                ez  = (ed == 4'h0);
                checks++;
                if ({diff4, borrowout4, overflow4, zero4} !== {ed, ebo, eov, ez}) begin
                    errors++;
                    $display("FAIL sweep4 %h-%h: got diff=%h bo=%b ov=%b z=%b required %h %b %b %b",
                             ea, eb, diff4, borrowout4, overflow4, zero4, ed, ebo, eov, ez);
                end
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev !== 6) begin
                        errors++;
                        $display("FAIL sweep4_spacing: got %0d required 6", cyc - prev);
                    end
                end
                prev = cyc;
                idx++;
                a4 = idx[7:4];
                b4 = idx[3:0];
                if (idx == 256) start4 = 1'b0;
            end
        end
        start4 = 1'b0;
        checks++;
        if (idx !== 256) begin
            errors++;
            $display("FAIL sweep4_count: got %0d done pulses required 256", idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_zero_hold();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: computes a − b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the full-adder cell and is the serial datapath block for the ALU work in this assignment. It uses a start/busy/done handshake. Results and flags are held in output registers until the next operation completes.

## Interface

- Parameters:
  - WIDTH, 8, operand and result width in bits (≥ 2)
- Ports:
  - clk  input  1  rising-edge clock; the only clock
  - rst_n  input  1  reset, asynchronous, active-low
  - start  input  1  request; sampled only in IDLE
  - a  input  WIDTH  minuend; sampled on the accepting edge only
  - b  input  WIDTH  subtrahend; sampled on the accepting edge only
  - busy  output  1  high while an operation is in SHIFT
  - done  output  1  single-cycle pulse; result registers are valid
  - diff  output  WIDTH  a − b modulo 2^WIDTH
  - borrowout  output  1  final borrow; 1 iff a < b unsigned
  - overflow  output  1  signed overflow of a − b
  - zero  output  1  diff == 0

## Operation

- FSM states:
  - IDLE → SHIFT on start=1. Latches a and b into shift registers. Clears the borrow flip-flop and the bit counter.
  - SHIFT stays in SHIFT for exactly WIDTH clock edges. Each edge processes operand bit i = count:
    - d = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d shifts into the result shift register from the MSB end. The operand registers shift right. count increments.
  - The edge that processes bit WIDTH−1 moves SHIFT → DONE. On that same edge it loads diff, borrowout, overflow and zero from the final values.
  - DONE → IDLE unconditionally on the next edge.
- Flags (computed from the latched operands):
  - overflow = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb)
  - zero = ~|diff
  - borrowout = br' from the last bit
- Handshake rules:
  - start is ignored in SHIFT and DONE. No queuing and no re-latching of a or b.
  - start held high continuously starts a new operation on each entry into IDLE.
- Output stability:
  - diff and the flags change only on the DONE-entry edge.
  - They hold their previous values throughout the next operation.
  - a and b may change freely after the accepting edge.
- Reset:
  - Asserting rst_n=0 at any time forces IDLE immediately, without waiting for a clock edge.
  - busy=0, done=0, diff=0, borrowout=0, overflow=0, zero=0. Internal shift registers, borrow and counter are cleared.
  - An operation interrupted by reset produces no done pulse.
  - Deassertion is synchronous to the design: the first edge with rst_n=1 may accept start.

## Timing

- Accepting edge E0 is a rising edge with state=IDLE and start=1.
- busy = 1 for cycles E0+1 through E0+WIDTH, which covers exactly WIDTH cycles. busy is combinationally equal to (state==SHIFT).
- done = 1 in exactly the one cycle after edge E0+WIDTH, and busy=0 in that cycle.
- Earliest next accept is edge E0+WIDTH+2, giving throughput of one operation per WIDTH+2 cycles.
- Latency from start to result valid is WIDTH edges.
- The counter wraps only via the SHIFT → DONE transition. No counter value ≥ WIDTH is ever used.
- No combinational path from inputs to outputs.

## Test plan

WIDTH=8 unless stated.

- Basic subtraction: 0x05 − 0x03.
  - diff=0x02, borrowout=0, overflow=0, zero=0.
  - done exactly 8 edges after the accepting edge; busy high for 8 cycles.
- Unsigned borrow: 0x03 − 0x05.
  - diff=0xFE, borrowout=1, overflow=0, zero=0.
- Signed overflow:
  - 0x80 − 0x01 → diff=0x7F, overflow=1, borrowout=0.
  - 0x7F − 0xFF → diff=0x80, overflow=1, borrowout=1.
- Zero result: 0x2A − 0x2A → diff=0x00, zero=1, borrowout=0, overflow=0.
  - Then pulse start with 0x01 − 0x00; outputs must stay at the previous values until that operation's done.
- Protocol and reset:
  - start asserted with new operands on cycles 3 and 7 of an operation → ignored; the result matches the original operands.
  - rst_n low for 1 ns mid-SHIFT → immediate zero outputs, no done, IDLE.
  - The next start completes normally.
- Exhaustive at WIDTH=4: all 256 (a, b) pairs back-to-back with start held high.
  - Every done cycle matches the reference a − b for diff and all three flags.
  - Spacing between done pulses is exactly 6 cycles.
